handshake_fifo: RTL and testbench

Elastic buffer node for the req/ack dataflow fabric. It sits directly downstream of an `out` operator, or between any two operators, and decouples producer and consumer timing. It pulls data from upstream with the same request/acknowledge protocol the producers and operators use, stores up to `depth` words in order, and serves them to a downstream requester. It is used to absorb consumer stalls when throughput is measured under non-zero `fail_rate`.

---
 rtl/handshake_fifo.sv | 98 +++++++++
 tb/tb_handshake_fifo.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_fifo.sv
// handshake_fifo: elastic buffer node for the req/ack dataflow fabric.
// Pulls words from upstream with a registered request / same-cycle acknowledge
// handshake, stores up to `depth` words in order, and serves them downstream
// with a registered one-cycle acknowledge.
//
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset
//   req_l  - registered request to upstream
//   ack_l  - upstream acknowledge, din valid in the same cycle
//   din    - upstream data
//   req_r  - downstream request
//   ack_r  - registered one-cycle acknowledge to downstream
//   dout   - registered data, valid while ack_r is high
//   level  - current occupancy
//   err    - sticky protocol-violation flag (ack_l without req_l)
module handshake_fifo #(
  parameter int unsigned data_width = 32,
  parameter int unsigned depth      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    req_l,
  input  logic                    ack_l,
  input  logic [data_width-1:0]   din,
  input  logic                    req_r,
  output logic                    ack_r,
  output logic [data_width-1:0]   dout,
  output logic [$clog2(depth):0]  level,
  output logic                    err
);

  localparam int unsigned AddrW  = $clog2(depth);
  localparam int unsigned LevelW = AddrW + 1;
  localparam logic [LevelW-1:0] LevelFull = LevelW'(depth);

  logic [data_width-1:0] r_mem [depth];
  logic [AddrW-1:0]      r_wp;
  logic [AddrW-1:0]      r_rp;
  logic [LevelW-1:0]     r_level;
  logic                  r_req_l;
  logic                  r_ack_r;
  logic [data_width-1:0] r_dout;
  logic                  r_err;

  logic                  w_wr;
  logic                  w_rd;
  logic [LevelW-1:0]     w_level_next;

  always_comb begin
    // A word arriving without a request is still stored when there is room.
    w_wr         = ack_l & (r_level < LevelFull);
    // Read uses the registered level only: no same-cycle bypass from din.
    w_rd         = req_r & ~r_ack_r & (r_level != '0);
    w_level_next = r_level + LevelW'(w_wr) - LevelW'(w_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_req_l <= 1'b0;
      r_ack_r <= 1'b0;
      r_dout  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_level <= w_level_next;
      // Request drops for one cycle after each ack, so at most one word is in flight.
      r_req_l <= ~ack_l & (w_level_next < LevelFull);
      r_ack_r <= w_rd;
      if (ack_l & ~r_req_l) begin
        r_err <= 1'b1;
      end
      if (w_wr) begin
        r_wp <= r_wp + AddrW'(1);
      end
      if (w_rd) begin
        r_dout <= r_mem[r_rp];
        r_rp   <= r_rp + AddrW'(1);
      end
    end
  end

  // Storage is not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_wr & ~rst) begin
      r_mem[r_wp] <= din;
    end
  end

  assign req_l = r_req_l;
  assign ack_r = r_ack_r;
  assign dout  = r_dout;
  assign level = r_level;
  assign err   = r_err;

endmodule

// File: tb/tb_handshake_fifo.sv
module tb_handshake_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          req_l;
  logic          ack_l;
  logic [DW-1:0] din;
  logic          req_r;
  logic          ack_r;
  logic [DW-1:0] dout;
  logic [2:0]    level;
  logic          err;

  handshake_fifo #(
    .data_width (DW),
    .depth      (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req_l (req_l),
    .ack_l (ack_l),
    .din   (din),
    .req_r (req_r),
    .ack_r (ack_r),
    .dout  (dout),
    .level (level),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Producer stimulus knobs.
  bit            prod_en = 0;
  int            prod_fail = 0;
  int            prod_sent = 0;
  int            prod_limit = 0;
  logic [DW-1:0] prod_base = '0;

  // Consumer stimulus knobs.
  bit cons_en = 0;
  int cons_fail = 0;

  // Behavioural reference: ordered queue of stored words plus protocol flags.
  logic [DW-1:0] m_q[$];
  bit            m_ack = 0;
  bit            m_req = 0;
  bit            m_err = 0;
  logic [DW-1:0] m_dout = '0;

  // Producer: acks a seen request (with a random refusal rate) and supplies the next value.
  initial begin
    ack_l = 1'b0;
    din   = '0;
    forever begin
      @(negedge clk);
      if (prod_en) begin
        if (req_l && prod_sent < prod_limit && $urandom_range(0, 99) >= prod_fail) begin
          ack_l = 1'b1;
          din   = prod_base + DW'(prod_sent);
          prod_sent++;
        end else begin
          ack_l = 1'b0;
        end
      end
    end
  end

  // Consumer: random request pattern when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (cons_en) req_r = ($urandom_range(0, 99) >= cons_fail);
    end
  end

  // Reference model update at each active edge.
  initial begin
    forever begin
      bit wr, rd;
      @(posedge clk);
      if (rst) begin
        m_q.delete();
        m_ack  = 0;
        m_req  = 0;
        m_err  = 0;
        m_dout = '0;
      end else begin
        wr = ack_l && (m_q.size() < DEPTH);
        rd = req_r && !m_ack && (m_q.size() > 0);
        if (ack_l && !m_req) m_err = 1;
        if (rd) m_dout = m_q.pop_front();
        m_ack = rd;
        if (wr) m_q.push_back(din);
        m_req = !ack_l && (m_q.size() < DEPTH);
      end
    end
  end

  task automatic do_reset();
    prod_en = 0;
    cons_en = 0;
    @(negedge clk);
    ack_l = 1'b0;
    req_r = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_level(input int target, input string name);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (int'(level) == target) hit = 1;
    end
    if (!hit) begin
      total_cnt++;
      $display("FAIL %s: level=%0d never reached required %0d", name, level, target);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    ack_l = 1'b0;
    req_r = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({req_l, ack_r, level, err} !== 6'b0)
      $display("FAIL reset_ctrl: req_l=%b ack_r=%b level=%0d err=%b required all 0",
               req_l, ack_r, level, err);
    else pass_cnt++;
    total_cnt++;
    if (dout !== '0) $display("FAIL reset_dout: dout=%h required 0", dout);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (req_l !== 1'b1) $display("FAIL first_req: req_l=%b required 1", req_l);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    do_reset();
    prod_sent = 0; prod_base = '0; prod_limit = 100; prod_fail = 0;
    req_r = 1'b0;
    prod_en = 1;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (level !== 3'd4) $display("FAIL fill_level: level=%0d required 4", level);
    else pass_cnt++;
    total_cnt++;
    if (req_l !== 1'b0) $display("FAIL fill_req: req_l=%b required 0", req_l);
    else pass_cnt++;
    total_cnt++;
    if (err !== 1'b0) $display("FAIL fill_err: err=%b required 0", err);
    else pass_cnt++;
    total_cnt++;
    if (prod_sent !== 4) $display("FAIL fill_accepted: accepted=%0d required 4", prod_sent);
    else pass_cnt++;
    prod_en = 0;
    @(negedge clk);
    ack_l = 1'b0;
  endtask

  task automatic test_drain();
    int  got = 0;
    int  first = -1;
    bit  prev = 0;
    req_r = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (first >= 0 && c == first + 1) begin
        total_cnt++;
        if (req_l !== 1'b1) $display("FAIL drain_req_reassert: req_l=%b required 1", req_l);
        else pass_cnt++;
      end
      if (ack_r) begin
        total_cnt++;
        if (dout !== DW'(got)) $display("FAIL drain_data: dout=%0d required %0d", dout, got);
        else pass_cnt++;
        total_cnt++;
        if (prev !== 1'b0) $display("FAIL drain_alternate: back-to-back ack_r at word %0d", got);
        else pass_cnt++;
        if (first < 0) first = c;
        got++;
      end
      prev = ack_r;
    end
    total_cnt++;
    if (got !== 4) $display("FAIL drain_count: acks=%0d required 4", got);
    else pass_cnt++;
    total_cnt++;
    if (level !== 3'd0 || ack_r !== 1'b0)
      $display("FAIL drain_empty: level=%0d ack_r=%b required 0/0", level, ack_r);
    else pass_cnt++;
    req_r = 1'b0;
  endtask

  task automatic test_stream();
    int recv = 0;
    int max_level = 0;
    do_reset();
    prod_sent = 0; prod_base = '0; prod_limit = 5000; prod_fail = 0;
    req_r = 1'b1;
    prod_en = 1;
    for (int c = 0; c < 12000 && recv < 5000; c++) begin
      @(negedge clk);
      if (int'(level) > max_level) max_level = int'(level);
      if (ack_r) begin
        total_cnt++;
        if (dout !== DW'(recv)) $display("FAIL stream_data: dout=%0d required %0d", dout, recv);
        else pass_cnt++;
        recv++;
      end
    end
    total_cnt++;
    if (recv !== 5000) $display("FAIL stream_count: received=%0d required 5000", recv);
    else pass_cnt++;
    total_cnt++;
    if (max_level > 1) $display("FAIL stream_level: max level=%0d required <=1", max_level);
    else pass_cnt++;
    total_cnt++;
    if (err !== 1'b0) $display("FAIL stream_err: err=%b required 0", err);
    else pass_cnt++;
    prod_en = 0;
  endtask

  task automatic test_random();
    int recv = 0;
    do_reset();
    prod_sent = 0; prod_base = 32'h1000; prod_limit = 40; prod_fail = 30;
    req_r = 1'b0;
    prod_en = 1;
    // Let it fill to 2 so reads and writes overlap around the wrap point.
    wait_level(2, "random_prefill");
    cons_fail = 50;
    cons_en = 1;
    for (int c = 0; c < 3000 && recv < 40; c++) begin
      @(negedge clk);
      total_cnt++;
      if (int'(level) !== m_q.size() || ack_r !== m_ack)
        $display("FAIL random_state: level=%0d ack_r=%b required %0d/%b",
                 level, ack_r, m_q.size(), m_ack);
      else pass_cnt++;
      if (ack_r) begin
        total_cnt++;
        if (dout !== 32'h1000 + DW'(recv))
          $display("FAIL random_order: dout=%h required %h", dout, 32'h1000 + DW'(recv));
        else pass_cnt++;
        recv++;
      end
    end
    total_cnt++;
    if (recv !== 40) $display("FAIL random_count: received=%0d required 40", recv);
    else pass_cnt++;
    cons_en = 0;
    prod_en = 0;
    req_r = 1'b0;
  endtask

  task automatic test_reset_mid();
    int recv = 0;
    do_reset();
    prod_sent = 0; prod_base = '0; prod_limit = 3; prod_fail = 0;
    req_r = 1'b0;
    prod_en = 1;
    wait_level(3, "midreset_fill");
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (level !== 3'd0 || ack_r !== 1'b0 || req_l !== 1'b0)
      $display("FAIL midreset_state: level=%0d ack_r=%b req_l=%b required 0/0/0",
               level, ack_r, req_l);
    else pass_cnt++;
    rst = 1'b0;
    prod_base = 32'd100; prod_limit = 2; prod_sent = 0;
    req_r = 1'b1;
    for (int c = 0; c < 30 && recv < 2; c++) begin
      @(negedge clk);
      if (ack_r) begin
        total_cnt++;
        if (dout !== 32'd100 + DW'(recv))
          $display("FAIL midreset_data: dout=%0d required %0d", dout, 100 + recv);
        else pass_cnt++;
        recv++;
      end
    end
    total_cnt++;
    if (recv !== 2) $display("FAIL midreset_count: received=%0d required 2", recv);
    else pass_cnt++;
    prod_en = 0;
    req_r = 1'b0;
  endtask

  task automatic test_violation();
    int recv = 0;
    do_reset();
    prod_sent = 0; prod_base = '0; prod_limit = 4; prod_fail = 0;
    req_r = 1'b0;
    prod_en = 1;
    wait_level(4, "violation_fill");
    prod_en = 0;
    ack_l = 1'b0;
    @(negedge clk);
    ack_l = 1'b1;
    din = 32'hDEAD_BEEF;
    @(negedge clk);
    ack_l = 1'b0;
    total_cnt++;
    if (level !== 3'd4) $display("FAIL violation_level: level=%0d required 4", level);
    else pass_cnt++;
    total_cnt++;
    if (err !== 1'b1) $display("FAIL violation_err: err=%b required 1", err);
    else pass_cnt++;
    req_r = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack_r) begin
        total_cnt++;
        if (dout !== DW'(recv)) $display("FAIL violation_data: dout=%h required %0d", dout, recv);
        else pass_cnt++;
        recv++;
      end
    end
    total_cnt++;
    if (recv !== 4 || level !== 3'd0)
      $display("FAIL violation_drop: received=%0d level=%0d required 4/0", recv, level);
    else pass_cnt++;
    total_cnt++;
    if (err !== 1'b1) $display("FAIL violation_sticky: err=%b required 1", err);
    else pass_cnt++;
    do_reset();
    total_cnt++;
    if (err !== 1'b0) $display("FAIL violation_clear: err=%b required 0", err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_random();
    test_reset_mid();
    test_violation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
